id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Parametrised, elastic ID→EX pipeline register. Successor to the fixed-width ID/EX latch.
- Adds a valid/ready handshake, an optional skid entry that registers the ready path, a synchronous flush, and control gating on invalid entries.
- Adds a writeback snoop that keeps held operands coherent while the stage is stalled.
- Sits between decode/register-read and the EX stage (ALU, forwarding and hazard logic).

Parameters:
- XLEN, 32, data, PC, instruction and immediate width.
- RA_W, 5, register address width.
- CTRL_W, 8, packed control width: {ALUop[1:0], ALUsrc, RegWrite, MemToReg, MemRead, MemWrite, spare}.
- SKID, 1, 1 = two-entry elastic buffer (in_ready registered); 0 = single entry (in_ready combinational from out_ready).

Ports:
- CLK  in  1  clock
- nRESET  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous kill of all held entries (branch or exception redirect)
- in_valid_i  in  1  ID presents an instruction
- in_ready_o  out  1  stage can accept an instruction this cycle
- pc_i, instr_i, rs1_data_i, rs2_data_i, imm_i  in  XLEN each  decode payload
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  RA_W each  register addresses
- ctrl_i  in  CTRL_W  packed control
- wb_en_i  in  1  writeback port write enable
- wb_addr_i  in  RA_W  writeback register address
- wb_data_i  in  XLEN  writeback data
- out_valid_o  out  1  EX holds a valid instruction
- out_ready_i  in  1  EX consumes the instruction this cycle
- pc_o, instr_o, rs1_data_o, rs2_data_o, imm_o  out  XLEN each  payload to EX
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  RA_W each  to forwarding unit
- ctrl_o  out  CTRL_W  control; forced to 0 when out_valid_o = 0

Behaviour:
- Reset (asynchronous, nRESET = 0):
  - All valid bits = 0 and all payload registers = 0.
  - Outputs: out_valid_o = 0, ctrl_o = 0, all data/address outputs = 0.
  - in_ready_o = 1 for SKID = 1. For SKID = 0, in_ready_o = 1 (no entry is held).
- Transfer rules:
  - Input transfer: in_valid_i && in_ready_o at a rising edge.
  - Output transfer: out_valid_o && out_ready_i at a rising edge.
  - Payload is held stable while out_valid_o && !out_ready_i.
- Latency: 1 cycle from input transfer to out_valid_o when the stage is empty.
- SKID = 0:
  - in_ready_o = !main_v || out_ready_i.
  - On input transfer, main is loaded and main_v = 1. Otherwise main_v is cleared on output transfer.
- SKID = 1, entries main (visible at the outputs) and skid:
  - in_ready_o = !skid_v, driven from a flop.
  - Input transfer, main free or draining this cycle: data goes to main.
  - Input transfer while main is stalled: data goes to skid.
  - Output transfer with skid_v = 1: skid moves to main and skid_v = 0 in the same edge.
  - Full (both valid): in_ready_o = 0. No input is accepted even if out_ready_i rises this cycle; it reasserts next cycle.
  - Order is preserved strictly: main is always older than skid.
- Flush:
  - flush_i = 1 at an edge clears main_v and skid_v.
  - Any same-cycle input transfer is discarded.
  - Flush has priority over input and output transfers.
  - Payload registers may keep stale data, but ctrl_o reads 0.
  - in_ready_o = 1 on the next cycle.
- Writeback snoop, applied every edge when wb_en_i && wb_addr_i != 0:
  - Held main/skid entries: if rs1_addr == wb_addr_i, rs1_data is replaced with wb_data_i; rs2 likewise.
  - Entries being loaded on this edge: the same comparison is made against the incoming rs*_addr_i, and wb_data_i overrides rs*_data_i.
  - Register 0 is never substituted.
- Output gating: ctrl_o = out_valid_o ? main_ctrl : 0. A bubble appears to EX as an all-zero control word (a NOP).
- Simultaneous events (SKID = 1, both entries full, out transfer and no flush): skid moves to main; in_ready_o stays 0 for that cycle.
- Reset asserted mid-stall: all entries drop immediately (asynchronously). No payload survives.

Test Plan:
- Reset then stream:
  - Drive nRESET = 0 → out_valid_o = 0, ctrl_o = 0, in_ready_o = 1.
  - Release reset, apply in_valid_i = 1 with pc 0x100/0x104/0x108 and out_ready_i = 1 → out pc 0x100, 0x104, 0x108 on consecutive cycles, 1-cycle latency.
- Backpressure (SKID = 1):
  - Set out_ready_i = 0 after pc 0x100 is visible.
  - Send 0x104, then offer 0x108 → 0x104 lands in skid, in_ready_o = 0 while 0x108 is offered.
  - Release out_ready_i → outputs 0x100, 0x104, 0x108 in order with no loss or duplication.
- Flush:
  - Hold two entries, assert flush_i with in_valid_i = 1 (pc 0x200) in the same cycle.
  - Next cycle: out_valid_o = 0, ctrl_o = 0, in_ready_o = 1, and 0x200 is never output.
- Snoop while stalled:
  - Held entry has rs1_addr = 5, rs1_data = 0x11. Apply wb_en_i = 1, wb_addr_i = 5, wb_data_i = 0xDEAD.
  - Next cycle: rs1_data_o = 0xDEAD.
  - Repeat with wb_addr_i = 0 → rs1_data_o unchanged.
- Snoop on capture:
  - Input transfer with rs2_addr_i = 7, rs2_data_i = 0x1, in the same cycle as wb_en_i = 1, wb_addr_i = 7, wb_data_i = 0x55.
  - rs2_data_o = 0x55.
- SKID = 0 build:
  - With out_ready_i = 0 and one entry held → in_ready_o = 0.
  - Assert out_ready_i = 1 → in_ready_o = 1 in the same cycle; a new entry is accepted while the old one drains.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Purpose : bundles the ID->EX stage handshake, decode payload, writeback snoop
//           and EX-side payload into one parameterised interface.
// Ports   : master = decode/EX side (drives inputs, reads outputs);
//           slave  = the id_ex_stage pipeline register itself.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 8
);
  // Control and handshake
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic              out_ready_i;
  // Decode payload
  logic [XLEN-1:0]   pc_i, instr_i, rs1_data_i, rs2_data_i, imm_i;
  logic [RA_W-1:0]   rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [CTRL_W-1:0] ctrl_i;
  // Writeback snoop port
  logic              wb_en_i;
  logic [RA_W-1:0]   wb_addr_i;
  logic [XLEN-1:0]   wb_data_i;
  // Payload to EX
  logic [XLEN-1:0]   pc_o, instr_o, rs1_data_o, rs2_data_o, imm_o;
  logic [RA_W-1:0]   rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [CTRL_W-1:0] ctrl_o;

  modport master (
    output flush_i, in_valid_i, out_ready_i,
    output pc_i, instr_i, rs1_data_i, rs2_data_i, imm_i,
    output rs1_addr_i, rs2_addr_i, rd_addr_i, ctrl_i,
    output wb_en_i, wb_addr_i, wb_data_i,
    input  in_ready_o, out_valid_o,
    input  pc_o, instr_o, rs1_data_o, rs2_data_o, imm_o,
    input  rs1_addr_o, rs2_addr_o, rd_addr_o, ctrl_o
  );

  modport slave (
    input  flush_i, in_valid_i, out_ready_i,
    input  pc_i, instr_i, rs1_data_i, rs2_data_i, imm_i,
    input  rs1_addr_i, rs2_addr_i, rd_addr_i, ctrl_i,
    input  wb_en_i, wb_addr_i, wb_data_i,
    output in_ready_o, out_valid_o,
    output pc_o, instr_o, rs1_data_o, rs2_data_o, imm_o,
    output rs1_addr_o, rs2_addr_o, rd_addr_o, ctrl_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// Purpose      : elastic ID->EX pipeline register with flush, NOP gating of ctrl
//                on bubbles and writeback snooping of held operands.
// Latency      : 1 cycle from input transfer to out_valid_o when empty.
// Backpressure : SKID=1 -> two entries, in_ready_o from a flop (= !skid_v);
//                SKID=0 -> one entry, in_ready_o = !main_v || out_ready_i.
// Ports        : CLK, nRESET (async active-low), io (id_ex_stage_if.slave).
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic          CLK,
  input  logic          nRESET,
  id_ex_stage_if.slave  io
);

  localparam logic SKID_EN = (SKID != 0);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   rs1_d;
    logic [XLEN-1:0]   rs2_d;
    logic [XLEN-1:0]   imm;
    logic [RA_W-1:0]   rs1_a;
    logic [RA_W-1:0]   rs2_a;
    logic [RA_W-1:0]   rd_a;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t r_main, r_skid;
  logic   r_main_v, r_skid_v, r_in_rdy;

  entry_t w_in_ent, w_main_nxt, w_skid_nxt;
  logic   w_main_v_nxt, w_skid_v_nxt;
  logic   w_in_rdy, w_in_xfer, w_out_xfer, w_main_free;
  logic   w_wb_act;

  assign w_in_ent = '{pc: io.pc_i, instr: io.instr_i, rs1_d: io.rs1_data_i,
                      rs2_d: io.rs2_data_i, imm: io.imm_i, rs1_a: io.rs1_addr_i,
                      rs2_a: io.rs2_addr_i, rd_a: io.rd_addr_i, ctrl: io.ctrl_i};

  // x0 is hard-wired zero, so writes to it must never be forwarded.
  assign w_wb_act    = io.wb_en_i && (io.wb_addr_i != '0);

  assign w_in_rdy    = SKID_EN ? r_in_rdy : (!r_main_v || io.out_ready_i);
  assign w_in_xfer   = io.in_valid_i && w_in_rdy;
  assign w_out_xfer  = r_main_v && io.out_ready_i;
  assign w_main_free = !r_main_v || w_out_xfer;

  // Replace stale operands of whatever entry lands in a register this edge.
  function automatic entry_t f_snoop(input entry_t e);
    entry_t r;
    r = e;
    if (w_wb_act && (e.rs1_a == io.wb_addr_i)) r.rs1_d = io.wb_data_i;
    if (w_wb_act && (e.rs2_a == io.wb_addr_i)) r.rs2_d = io.wb_data_i;
    return r;
  endfunction

  always_comb begin
    w_main_nxt   = f_snoop(r_main);
    w_skid_nxt   = f_snoop(r_skid);
    w_main_v_nxt = r_main_v;
    w_skid_v_nxt = r_skid_v;
    if (io.flush_i) begin
      // Flush wins over everything; same-cycle input is dropped.
      w_main_v_nxt = 1'b0;
      w_skid_v_nxt = 1'b0;
    end else if (r_skid_v) begin
      // Full: in_ready_o is low, so only the skid->main shift can happen.
      if (w_out_xfer) begin
        w_main_nxt   = f_snoop(r_skid);
        w_skid_v_nxt = 1'b0;
      end
    end else if (w_in_xfer) begin
      if (w_main_free) begin
        w_main_nxt   = f_snoop(w_in_ent);
        w_main_v_nxt = 1'b1;
      end else if (SKID_EN) begin
        w_skid_nxt   = f_snoop(w_in_ent);
        w_skid_v_nxt = 1'b1;
      end
    end else if (w_out_xfer) begin
      w_main_v_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_in_rdy <= 1'b1;
    end else begin
      r_main   <= w_main_nxt;
      r_skid   <= w_skid_nxt;
      r_main_v <= w_main_v_nxt;
      r_skid_v <= w_skid_v_nxt;
      // Registered ready: tracks the skid slot becoming free next cycle.
      r_in_rdy <= !w_skid_v_nxt;
    end
  end

  assign io.in_ready_o  = w_in_rdy;
  assign io.out_valid_o = r_main_v;
  assign io.pc_o        = r_main.pc;
  assign io.instr_o     = r_main.instr;
  assign io.rs1_data_o  = r_main.rs1_d;
  assign io.rs2_data_o  = r_main.rs2_d;
  assign io.imm_o       = r_main.imm;
  assign io.rs1_addr_o  = r_main.rs1_a;
  assign io.rs2_addr_o  = r_main.rs2_a;
  assign io.rd_addr_o   = r_main.rd_a;
  // Bubbles reach EX as an all-zero control word (NOP).
  assign io.ctrl_o      = r_main_v ? r_main.ctrl : '0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Purpose : self-checking bench for id_ex_stage, SKID=1 and SKID=0 builds.
// Ports   : none; instantiates two interfaces and two DUTs on a shared CLK/nRESET.
module tb_id_ex_stage;

  logic CLK;
  logic nRESET;
  int   n_chk;
  int   n_fail;

  id_ex_stage_if #(.XLEN(32), .RA_W(5), .CTRL_W(8)) u_if1 ();
  id_ex_stage_if #(.XLEN(32), .RA_W(5), .CTRL_W(8)) u_if0 ();

  id_ex_stage #(.XLEN(32), .RA_W(5), .CTRL_W(8), .SKID(1)) u_dut1 (
    .CLK(CLK), .nRESET(nRESET), .io(u_if1)
  );
  id_ex_stage #(.XLEN(32), .RA_W(5), .CTRL_W(8), .SKID(0)) u_dut0 (
    .CLK(CLK), .nRESET(nRESET), .io(u_if0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [31:0] epc;
    logic        irdy;
  } vec_t;

  vec_t vt[14];

  function automatic logic [7:0] ctrl_of(input logic [31:0] pc);
    return pc[9:2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive1(input logic iv, input logic [31:0] pc, input logic ordy,
                        input logic fl);
    u_if1.in_valid_i  = iv;
    u_if1.pc_i        = pc;
    u_if1.instr_i     = pc ^ 32'hA5A5_0000;
    u_if1.ctrl_i      = ctrl_of(pc);
    u_if1.rs1_addr_i  = 5'd1;
    u_if1.rs2_addr_i  = 5'd2;
    u_if1.rd_addr_i   = 5'd3;
    u_if1.rs1_data_i  = pc + 32'd1;
    u_if1.rs2_data_i  = pc + 32'd2;
    u_if1.imm_i       = 32'h0;
    u_if1.out_ready_i = ordy;
    u_if1.flush_i     = fl;
    u_if1.wb_en_i     = 1'b0;
    u_if1.wb_addr_i   = 5'd0;
    u_if1.wb_data_i   = 32'h0;
  endtask

  task automatic drive0(input logic iv, input logic [31:0] pc, input logic ordy);
    u_if0.in_valid_i  = iv;
    u_if0.pc_i        = pc;
    u_if0.instr_i     = 32'h0;
    u_if0.ctrl_i      = ctrl_of(pc);
    u_if0.rs1_addr_i  = 5'd1;
    u_if0.rs2_addr_i  = 5'd2;
    u_if0.rd_addr_i   = 5'd3;
    u_if0.rs1_data_i  = 32'h0;
    u_if0.rs2_data_i  = 32'h0;
    u_if0.imm_i       = 32'h0;
    u_if0.out_ready_i = ordy;
    u_if0.flush_i     = 1'b0;
    u_if0.wb_en_i     = 1'b0;
    u_if0.wb_addr_i   = 5'd0;
    u_if0.wb_data_i   = 32'h0;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    //           iv    pc          ordy  fl    ov    epc         irdy
    // stream
    vt[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1};
    vt[1]  = '{1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 32'h104, 1'b1};
    vt[2]  = '{1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h108, 1'b1};
    vt[3]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000, 1'b1};
    // backpressure: 0x104 into skid, 0x108 refused while full
    vt[4]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1};
    vt[5]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0};
    vt[6]  = '{1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0};
    vt[7]  = '{1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h104, 1'b1};
    vt[8]  = '{1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h108, 1'b1};
    vt[9]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000, 1'b1};
    // flush with two entries held and 0x200 offered in the same cycle
    vt[10] = '{1'b1, 32'h1F0, 1'b0, 1'b0, 1'b1, 32'h1F0, 1'b1};
    vt[11] = '{1'b1, 32'h1F4, 1'b0, 1'b0, 1'b1, 32'h1F0, 1'b0};
    vt[12] = '{1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1};
    vt[13] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000, 1'b1};

    drive1(1'b0, 32'h0, 1'b0, 1'b0);
    drive0(1'b0, 32'h0, 1'b0);
    nRESET = 1'b0;
    #12;
    chk("rst_ov1",   32'(u_if1.out_valid_o), 32'd0);
    chk("rst_ctrl1", 32'(u_if1.ctrl_o),      32'd0);
    chk("rst_irdy1", 32'(u_if1.in_ready_o),  32'd1);
    chk("rst_pc1",   u_if1.pc_o,             32'd0);
    chk("rst_rs1_1", u_if1.rs1_data_o,       32'd0);
    chk("rst_ov0",   32'(u_if0.out_valid_o), 32'd0);
    chk("rst_irdy0", 32'(u_if0.in_ready_o),  32'd1);
    @(negedge CLK);
    nRESET = 1'b1;
    #1;

    // Table-driven vectors on the SKID=1 build.
    for (int i = 0; i < 14; i++) begin
      drive1(vt[i].iv, vt[i].pc, vt[i].ordy, vt[i].fl);
      tick();
      chk($sformatf("v%0d_ov", i),   32'(u_if1.out_valid_o), 32'(vt[i].ov));
      chk($sformatf("v%0d_irdy", i), 32'(u_if1.in_ready_o),  32'(vt[i].irdy));
      if (vt[i].ov) begin
        chk($sformatf("v%0d_pc", i),   u_if1.pc_o,        vt[i].epc);
        chk($sformatf("v%0d_ctrl", i), 32'(u_if1.ctrl_o), 32'(ctrl_of(vt[i].epc)));
        chk($sformatf("v%0d_instr", i), u_if1.instr_o,    vt[i].epc ^ 32'hA5A5_0000);
      end else begin
        chk($sformatf("v%0d_ctrl0", i), 32'(u_if1.ctrl_o), 32'd0);
      end
    end

    // Snoop on a held main entry, and x0 never substituted.
    drive1(1'b1, 32'h300, 1'b0, 1'b0);
    u_if1.rs1_addr_i = 5'd5;  u_if1.rs1_data_i = 32'h11;
    u_if1.rs2_addr_i = 5'd0;  u_if1.rs2_data_i = 32'h33;
    tick();
    chk("snp_hold_rs1", u_if1.rs1_data_o, 32'h11);
    drive1(1'b1, 32'h304, 1'b0, 1'b0);
    u_if1.rs1_addr_i = 5'd1;  u_if1.rs1_data_i = 32'h44;
    u_if1.rs2_addr_i = 5'd9;  u_if1.rs2_data_i = 32'h22;
    u_if1.wb_en_i = 1'b1; u_if1.wb_addr_i = 5'd5; u_if1.wb_data_i = 32'hDEAD;
    tick();
    chk("snp_main_rs1", u_if1.rs1_data_o, 32'hDEAD);
    chk("snp_full_irdy", 32'(u_if1.in_ready_o), 32'd0);
    drive1(1'b0, 32'h0, 1'b0, 1'b0);
    u_if1.wb_en_i = 1'b1; u_if1.wb_addr_i = 5'd0; u_if1.wb_data_i = 32'hBEEF;
    tick();
    chk("snp_x0_rs1", u_if1.rs1_data_o, 32'hDEAD);
    chk("snp_x0_rs2", u_if1.rs2_data_o, 32'h33);
    // Snoop on the held skid entry, visible once it shifts into main.
    u_if1.wb_addr_i = 5'd9; u_if1.wb_data_i = 32'h99;
    tick();
    drive1(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("snp_skid_pc",  u_if1.pc_o,       32'h304);
    chk("snp_skid_rs2", u_if1.rs2_data_o, 32'h99);
    chk("snp_skid_rs1", u_if1.rs1_data_o, 32'h44);
    tick();
    chk("snp_drain_ov", 32'(u_if1.out_valid_o), 32'd0);

    // Snoop on capture.
    drive1(1'b1, 32'h400, 1'b1, 1'b0);
    u_if1.rs2_addr_i = 5'd7; u_if1.rs2_data_i = 32'h1;
    u_if1.wb_en_i = 1'b1; u_if1.wb_addr_i = 5'd7; u_if1.wb_data_i = 32'h55;
    tick();
    chk("cap_ov",  32'(u_if1.out_valid_o), 32'd1);
    chk("cap_rs2", u_if1.rs2_data_o,       32'h55);
    drive1(1'b0, 32'h0, 1'b1, 1'b0);
    tick();

    // SKID=0 build: combinational ready follows out_ready_i.
    drive0(1'b1, 32'h500, 1'b0);
    tick();
    chk("s0_ov", 32'(u_if0.out_valid_o), 32'd1);
    chk("s0_pc", u_if0.pc_o, 32'h500);
    drive0(1'b1, 32'h504, 1'b0);
    #1;
    chk("s0_irdy_stall", 32'(u_if0.in_ready_o), 32'd0);
    u_if0.out_ready_i = 1'b1;
    #1;
    chk("s0_irdy_drain", 32'(u_if0.in_ready_o), 32'd1);
    tick();
    chk("s0_ov2",   32'(u_if0.out_valid_o), 32'd1);
    chk("s0_pc2",   u_if0.pc_o,             32'h504);
    chk("s0_ctrl2", 32'(u_if0.ctrl_o),      32'(ctrl_of(32'h504)));
    drive0(1'b0, 32'h0, 1'b1);
    tick();
    chk("s0_ov3",   32'(u_if0.out_valid_o), 32'd0);
    chk("s0_ctrl3", 32'(u_if0.ctrl_o),      32'd0);

    // Asynchronous reset in the middle of a stall.
    drive1(1'b1, 32'h600, 1'b0, 1'b0);
    tick();
    chk("ar_pre_ov", 32'(u_if1.out_valid_o), 32'd1);
    drive1(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    nRESET = 1'b0;
    #1;
    chk("ar_ov",   32'(u_if1.out_valid_o), 32'd0);
    chk("ar_pc",   u_if1.pc_o,             32'd0);
    chk("ar_ctrl", 32'(u_if1.ctrl_o),      32'd0);
    chk("ar_irdy", 32'(u_if1.in_ready_o),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
